// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: one spare bit above what is needed to index WIDTH bits.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the block is idle.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: n/a.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through a single full-subtractor cell and a registered borrow.
// Latency: start edge + WIDTH processing edges; done pulses one cycle after the last bit.
// Backpressure: start is ignored (not queued) while RUN or DONE.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Control FSM and datapath: load on start, one bit per edge in RUN, one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        // Operand MSBs are kept aside: the shift registers lose them.
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so bit 0 ends up at diff[0] after WIDTH shifts.
                    diff_q <= {cell_d, diff_q[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // cell_d is the final diff MSB being shifted in this edge.
                        ovf_q  <= (a_msb != b_msb) && (cell_d != a_msb);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = borrow;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start with the given operands and watch the whole transaction.
    // With interfere set, a second start with other operands is raised mid-RUN.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_op,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input bit interfere);
        int       busy_cnt;
        int       done_cnt;
        int       done_at;
        logic [7:0] got_diff;
        logic     got_bout;
        logic     got_ovf;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        got_diff = 8'hxx;
        got_bout = 1'bx;
        got_ovf  = 1'bx;
        bus.a     = ta;
        bus.b     = tb_op;
        bus.start = 1'b1;
        step();                       // edge E0 accepts start
        bus.start = 1'b0;
        // Sample k is taken after edge E_k (k edges after the start edge).
        for (int k = 0; k < 14; k++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at  = k;
                    got_diff = bus.diff;
                    got_bout = bus.bout;
                    got_ovf  = bus.ovf;
                end
            end
            if (interfere && k == 3) begin
                bus.a     = 8'h01;
                bus.b     = 8'h02;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " done_edge"}, 32'(done_at), 32'd8);
        check({tag, " diff"}, {24'd0, got_diff}, {24'd0, ed});
        check({tag, " bout"}, {31'd0, got_bout}, {31'd0, eb});
        check({tag, " ovf"}, {31'd0, got_ovf}, {31'd0, eo});
        // Results must persist in IDLE after the transaction.
        check({tag, " diff_held"}, {24'd0, bus.diff}, {24'd0, ed});
        check({tag, " busy_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int done_seen;
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h3C;
        bus.b     = 8'h15;

        // Reset held two cycles with start high: nothing may start.
        step();
        step();
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset diff", {24'd0, bus.diff}, 32'd0);
        check("reset bout", {31'd0, bus.bout}, 32'd0);
        check("reset ovf",  {31'd0, bus.ovf},  32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        check("post-reset idle busy", {31'd0, bus.busy}, 32'd0);

        run_op("sub_3c_15", 8'h3C, 8'h15, 8'h27, 1'b0, 1'b0, 1'b0);
        run_op("sub_15_3c", 8'h15, 8'h3C, 8'hD9, 1'b1, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op("sub_ff_ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op("start_in_run", 8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1, 1'b1);

        // Reset during RUN cycle 4: aborts with outputs cleared and no done pulse.
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check("mid-run busy before reset", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort diff", {24'd0, bus.diff}, 32'd0);
        check("abort bout", {31'd0, bus.bout}, 32'd0);
        check("abort ovf",  {31'd0, bus.ovf},  32'd0);
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
            step();
        end
        check("abort no done/busy", 32'(done_seen), 32'd0);

        run_op("after_abort", 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d failures %0d", n_checks, n_fails);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes a − b one bit per clock, LSB first, by reusing a single 1-bit full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the combinational full-adder cell in the arithmetic library. It trades WIDTH+2 cycles of latency for one 1-bit cell. A simple start/done handshake lets it sit behind a controller or a small ALU sequencer.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction. Accepted only in IDLE.
- a  input  WIDTH  minuend. Sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend. Sampled on the edge that accepts start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  single-cycle pulse: result valid.
- diff  output  WIDTH  a − b modulo 2^WIDTH.
- bout  output  1  final borrow: 1 when a < b unsigned.
- ovf  output  1  signed (two's complement) overflow of a − b.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on start=1. Load a and b into shift registers, clear the borrow flop, clear the bit counter.
  - RUN: each edge feeds a_sr[0], b_sr[0] and the borrow into the 1-bit cell.
    - d = a^b^bin.
    - bo = (~a & b) | (~(a^b) & bin).
    - Shift d into diff from the MSB end; shift a_sr and b_sr right; register bo; increment the counter.
  - RUN → DONE after the edge that processes bit WIDTH−1.
  - DONE → IDLE unconditionally after one cycle.
- Output meanings:
  - bout = the borrow registered after bit WIDTH−1.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]). Uses a captured copy of the operand MSBs.
  - busy = (state == RUN).
  - done = (state == DONE).
- start while in RUN or DONE: ignored. Not queued, and operands are not re-sampled.
- diff, bout and ovf hold their final values from DONE through IDLE until the next accepted start. During RUN their values are deterministic but not valid for consumers.
- Reset:
  - Takes priority over everything, including mid-RUN. It aborts the operation with no done pulse.
  - State → IDLE. busy, done, diff, bout, ovf, borrow, counter and shift registers all → 0.

## Timing
- Edge E0 samples start=1 in IDLE.
- Edges E1..E_WIDTH process bits 0..WIDTH−1. busy is high for exactly WIDTH cycles.
- done is high for exactly one cycle, the cycle after E_WIDTH. The result is valid in that cycle.
- Minimum start-to-start spacing is WIDTH+2 edges. A start held high continuously restarts on the first IDLE cycle after DONE.
- No combinational path from any input to any output.

## Structure
- Shared package serial_arith_pkg:
  - State enum (IDLE, RUN, DONE).
  - Counter width constant, $clog2(WIDTH)+1.
- Sub-module full_subtractor: a combinational 1-bit cell with ports a, b, bin, d, bout. Instantiated once. It is reusable by a future ripple subtractor.
- Everything else is one sequential process plus next-state logic: about 150–250 lines.

## Test plan (WIDTH=8)
- Reset: assert rst 2 cycles, with start=1 held during reset → busy=0, done=0, diff=0x00, bout=0, ovf=0. No operation starts until after rst falls.
- a=0x3C, b=0x15, start pulse → busy high 8 cycles. done pulses at cycle 9 after the start edge with diff=0x27, bout=0, ovf=0.
- a=0x15, b=0x3C → diff=0xD9, bout=1, ovf=0. Also a=0x80, b=0x01 → diff=0x7F, bout=0, ovf=1.
- Edge operands:
  - a=0x00, b=0xFF → diff=0x01, bout=1, ovf=0.
  - a=0xFF, b=0xFF → diff=0x00, bout=0, ovf=0.
- Start during RUN with different operands → ignored. The first result is unchanged, exactly one done pulse occurs, and busy is not extended.
- rst asserted at RUN cycle 4 → next cycle shows busy=0 and all outputs 0, with no done pulse. A new start after that completes correctly in 10 cycles.
